pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush/redirect controller for the 5-stage MIPS pipeline, and the consumer of the EX-stage forwarding unit's load-use flag. It turns load-use, EX-stage branch resolution, ERET and external interrupt lines into per-latch stall and flush strobes plus a PC redirect. It also holds the interrupt pending bits, the EPC and the in-handler state.

## Interface
- PC_W, 32, PC and target width
- INT_NUM, 3, number of external interrupt lines; line 0 has highest priority
- VEC_BASE, 32'h0000_0080, handler vector base; line i enters at VEC_BASE + 4*i
- clk  in  1  pipeline clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- load_use  in  1  load-use flag from the EX forwarding unit
- ex_valid  in  1  EX stage holds a real instruction, not a bubble
- ex_pc  in  PC_W  PC of the instruction in EX
- branch_taken  in  1  branch/jump in EX resolved taken
- branch_target  in  PC_W  resolved target
- eret  in  1  EX instruction is ERET
- int_req  in  INT_NUM  raw level interrupt lines, synchronous to clk
- int_mask  in  INT_NUM  1 = line enabled
- pc_stall, ifid_stall, idex_stall  out  1 each  hold the PC, IF/ID and ID/EX latches
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble into the IF/ID, ID/EX and EX/MEM latches
- pc_redirect  out  1  the PC loads pc_target next edge
- pc_target  out  PC_W  redirect address
- int_ack  out  INT_NUM  one-hot, one-cycle pulse on interrupt entry
- epc  out  PC_W  saved return PC
- in_handler  out  1  between interrupt entry and ERET
- lu_stall_cnt  out  32  count of load-use bubbles inserted; saturating

## Operation
- States: RUN, LU_STALL, HANDLER. HANDLER behaves as RUN except that no interrupt is taken.
- Stall/flush/redirect outputs are combinational from the current state and inputs. State, pending, epc and the counter are registered.
- Event priority within one cycle: load-use > interrupt > ERET > branch. A lower-priority event is ignored in a cycle where a higher one fires; the EX instruction re-presents it later.
- Load-use:
  - Condition: state RUN or HANDLER, and load_use & ex_valid.
  - Assert pc_stall, ifid_stall, idex_stall and exmem_flush. Next state LU_STALL. lu_stall_cnt += 1, saturating at 0xFFFF_FFFF.
- LU_STALL:
  - load_use is ignored; the load is now in WB and forwarding resolves.
  - Interrupt, ERET and branch are evaluated normally.
  - Return to the state held before the stall (RUN or HANDLER), tracked by a saved bit.
- Pending interrupts:
  - A rising edge on int_req[i] (versus the previous-cycle register) sets pend[i].
  - Take condition: state RUN or LU_STALL-from-RUN, ex_valid, and |(pend & int_mask).
  - Winner = lowest set index i.
- Interrupt take:
  - pc_redirect=1, pc_target = VEC_BASE + 4*i.
  - Flush ifid, idex and exmem; the EX instruction is squashed.
  - epc <= ex_pc; int_ack[i]=1; pend[i] cleared.
  - Next state HANDLER; in_handler=1.
- ERET: state HANDLER (or LU_STALL-from-HANDLER) and eret & ex_valid:
  - pc_redirect=1, pc_target=epc.
  - Flush ifid and idex; exmem is not flushed, since ERET has no write.
  - Next state RUN; in_handler=0.
- ERET in RUN is treated as a NOP: no redirect.
- Branch: branch_taken & ex_valid:
  - pc_redirect=1, pc_target=branch_target.
  - Flush ifid and idex.
- ex_valid=0: no event fires. Pending bits keep accumulating.

## Timing
- Reset values:
  - State RUN; pend=0; prev int_req=0; epc=0; in_handler=0; lu_stall_cnt=0.
  - All strobes, pc_redirect and int_ack are 0; pc_target=0.
- A load-use bubble costs exactly 1 cycle. load_use held high across two cycles yields one bubble, not two.
- Interrupt latency: edge at cycle n sets pend at edge n+1. The earliest take is cycle n+1 if EX is valid and no load-use; the redirect takes effect at edge n+2.
- An edge arriving on line i in the same cycle as the ack of line i: the set wins and pend[i] stays 1.
- Masked pending bits persist; unmasking later allows the take.
- Reset asserted mid-handler or mid-stall returns to RUN immediately. epc is cleared.

## Structure
- Shared package pipe_ctrl_pkg:
  - state enum (RUN/LU_STALL/HANDLER);
  - VEC_BASE default;
  - per-stage stall/flush bit positions for reuse by the pipeline latches.
- One sub-module, int_pending_reg: edge detect, sticky pend, mask, priority encode (index + valid).

## Test plan
- Load-use at cycle 5, load_use held through cycle 6 → stall trio plus exmem_flush in cycle 5 only; lu_stall_cnt=1.
- Branch, target 0x0040_0100 → pc_redirect=1, pc_target=0x0040_0100, ifid_flush=idex_flush=1, exmem_flush=0.
- int_req[2] rises with mask=3'b111, ex_pc=0x0040_0020 → one cycle later: int_ack=3'b100, pc_target=0x0000_0088, epc=0x0040_0020, all three flushes asserted, in_handler=1.
- Lines 1 and 2 rise together → line 1 acked first; after ERET (pc_target=epc) line 2 is taken on the next valid EX cycle.
- load_use, branch_taken and a pending interrupt in the same cycle → only the load-use stall. Next cycle (LU_STALL) → interrupt taken, and the branch is ignored.
- rst_n dropped asynchronously while in HANDLER with pend=3'b010 → in_handler, pend, epc and all outputs are 0 before the next clk edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline stall/flush/redirect controller and
//   the pipeline latches that consume its strobes.
//   - state_t      : controller state (RUN / LU_STALL / HANDLER)
//   - VEC_BASE_DEF : default interrupt handler vector base
//   - STALL_* / FLUSH_* : bit positions inside the per-stage stall and flush
//                         vectors, so latch code can index them by name.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        HANDLER  = 2'd2
    } state_t;

    localparam logic [31:0] VEC_BASE_DEF = 32'h0000_0080;

    // Stall vector: which latches hold their contents this cycle.
    localparam int STALL_PC   = 0;
    localparam int STALL_IFID = 1;
    localparam int STALL_IDEX = 2;
    localparam int STALL_W    = 3;

    // Flush vector: which latches load a bubble at the next edge.
    localparam int FLUSH_IFID  = 0;
    localparam int FLUSH_IDEX  = 1;
    localparam int FLUSH_EXMEM = 2;
    localparam int FLUSH_W     = 3;

endpackage

// File: rtl/int_pending_reg.sv
// int_pending_reg
//   Interrupt pending register: rising-edge detect on the raw request
//   lines, sticky pending bits, masking and a lowest-index-wins priority
//   encoder.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   int_req      : raw level request lines, synchronous to clk
//   int_mask     : 1 = line enabled for selection
//   clr, clr_idx : clear pend[clr_idx] at the next edge (interrupt taken)
//   pend         : sticky pending bits
//   win_idx      : lowest enabled pending line
//   win_valid    : at least one enabled line is pending
module int_pending_reg
    import pipe_ctrl_pkg::*;
#(
    parameter int INT_NUM = 3,
    parameter int IDX_W   = (INT_NUM > 1) ? $clog2(INT_NUM) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INT_NUM-1:0] int_req,
    input  logic [INT_NUM-1:0] int_mask,
    input  logic               clr,
    input  logic [IDX_W-1:0]   clr_idx,
    output logic [INT_NUM-1:0] pend,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_valid
);

    logic [INT_NUM-1:0] req_q;
    logic [INT_NUM-1:0] rise;
    logic [INT_NUM-1:0] clr_vec;
    logic [INT_NUM-1:0] active;

    assign rise    = int_req & ~req_q;
    assign clr_vec = clr ? (INT_NUM'(1) << clr_idx) : '0;
    assign active  = pend & int_mask;

    // A new edge on a line being acknowledged in the same cycle must not be
    // lost, so the set term is applied after the clear term.
    // NOTE: non-blocking assignments for all flops, so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            pend  <= '0;
        end else begin
            req_q <= int_req;
            pend  <= (pend & ~clr_vec) | rise;
        end
    end

    // Scan from the top down so the lowest active index is the last write.
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        for (int i = INT_NUM - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_idx   = IDX_W'(i);
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush/redirect controller for the 5-stage pipeline.
//   Resolves, in priority order, load-use > interrupt > ERET > taken branch,
//   and produces per-latch stall/flush strobes plus a PC redirect. Holds the
//   interrupt pending bits, the EPC and the in-handler state.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   load_use, ex_valid, ex_pc     : hazard flag and EX-stage instruction info
//   branch_taken, branch_target   : EX-stage branch resolution
//   eret                          : EX instruction is ERET
//   int_req, int_mask             : interrupt lines and enables
//   pc_stall/ifid_stall/idex_stall: hold the PC, IF/ID, ID/EX latches
//   ifid/idex/exmem_flush         : bubble into IF/ID, ID/EX, EX/MEM
//   pc_redirect, pc_target        : PC loads pc_target at the next edge
//   int_ack                       : one-hot pulse in the interrupt-take cycle
//   epc                           : saved return PC
//   in_handler                    : between interrupt entry and ERET
//   lu_stall_cnt                  : saturating count of load-use bubbles
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          PC_W     = 32,
    parameter int          INT_NUM  = 3,
    parameter logic [31:0] VEC_BASE = VEC_BASE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_use,
    input  logic               ex_valid,
    input  logic [PC_W-1:0]    ex_pc,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               eret,
    input  logic [INT_NUM-1:0] int_req,
    input  logic [INT_NUM-1:0] int_mask,
    output logic               pc_stall,
    output logic               ifid_stall,
    output logic               idex_stall,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               exmem_flush,
    output logic               pc_redirect,
    output logic [PC_W-1:0]    pc_target,
    output logic [INT_NUM-1:0] int_ack,
    output logic [PC_W-1:0]    epc,
    output logic               in_handler,
    output logic [31:0]        lu_stall_cnt
);

    localparam int IDX_W = (INT_NUM > 1) ? $clog2(INT_NUM) : 1;

    state_t             state;
    logic               lu_from_handler;   // state to return to after a bubble
    logic [INT_NUM-1:0] pend;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;

    logic               lu_ev;
    logic               take_ev;
    logic               eret_ev;
    logic               br_ev;
    logic [STALL_W-1:0] stall_vec;
    logic [FLUSH_W-1:0] flush_vec;

    int_pending_reg #(
        .INT_NUM (INT_NUM),
        .IDX_W   (IDX_W)
    ) u_pend (
        .clk       (clk),
        .rst_n     (rst_n),
        .int_req   (int_req),
        .int_mask  (int_mask),
        .clr       (take_ev),
        .clr_idx   (win_idx),
        .pend      (pend),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    // In LU_STALL the saved bit says whether we are still inside a handler.
    assign in_handler = (state == HANDLER) ||
                        ((state == LU_STALL) && lu_from_handler);

    // Events are gated by rst_n so that every strobe drops to zero as soon as
    // reset is asserted, without waiting for a clock edge.
    always_comb begin
        lu_ev   = rst_n && ex_valid && load_use && (state != LU_STALL);
        take_ev = rst_n && ex_valid && !lu_ev && !in_handler && win_valid;
        eret_ev = rst_n && ex_valid && !lu_ev && !take_ev && in_handler && eret;
        br_ev   = rst_n && ex_valid && !lu_ev && !take_ev && !eret_ev &&
                  branch_taken;
    end

    always_comb begin
        stall_vec = '0;
        flush_vec = '0;
        pc_target = '0;
        int_ack   = '0;

        stall_vec[STALL_PC]   = lu_ev;
        stall_vec[STALL_IFID] = lu_ev;
        stall_vec[STALL_IDEX] = lu_ev;

        flush_vec[FLUSH_IFID]  = take_ev || eret_ev || br_ev;
        flush_vec[FLUSH_IDEX]  = take_ev || eret_ev || br_ev;
        // The load moves on while the younger instruction is held in ID/EX,
        // so EX/MEM receives a bubble; an interrupt squashes the EX
        // instruction itself. ERET and branches have no write to cancel.
        flush_vec[FLUSH_EXMEM] = lu_ev || take_ev;

        if (take_ev) begin
            pc_target = PC_W'(VEC_BASE) + (PC_W'(win_idx) << 2);
            int_ack   = INT_NUM'(1) << win_idx;
        end else if (eret_ev) begin
            pc_target = epc;
        end else if (br_ev) begin
            pc_target = branch_target;
        end
    end

    assign pc_stall    = stall_vec[STALL_PC];
    assign ifid_stall  = stall_vec[STALL_IFID];
    assign idex_stall  = stall_vec[STALL_IDEX];
    assign ifid_flush  = flush_vec[FLUSH_IFID];
    assign idex_flush  = flush_vec[FLUSH_IDEX];
    assign exmem_flush = flush_vec[FLUSH_EXMEM];
    assign pc_redirect = take_ev || eret_ev || br_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            lu_from_handler <= 1'b0;
            epc             <= '0;
            lu_stall_cnt    <= '0;
        end else begin
            if (lu_ev) begin
                state           <= LU_STALL;
                lu_from_handler <= in_handler;
                if (lu_stall_cnt != 32'hFFFF_FFFF) begin
                    lu_stall_cnt <= lu_stall_cnt + 32'd1;
                end
            end else if (take_ev) begin
                state <= HANDLER;
                epc   <= ex_pc;
            end else if (eret_ev) begin
                state <= RUN;
            end else begin
                case (state)
                    LU_STALL: state <= lu_from_handler ? HANDLER : RUN;
                    HANDLER:  state <= HANDLER;
                    default:  state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Self-checking bench: a table of single-cycle vectors from reset, hand
//   sequences for the multi-cycle corner cases, and a randomized run checked
//   against a behavioural model of the controller's rules.
module tb_pipeline_hazard_ctrl;

    localparam int          PC_W    = 32;
    localparam int          INT_NUM = 3;
    localparam logic [31:0] VEC     = 32'h0000_0080;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               load_use = 1'b0;
    logic               ex_valid = 1'b0;
    logic [PC_W-1:0]    ex_pc = '0;
    logic               branch_taken = 1'b0;
    logic [PC_W-1:0]    branch_target = '0;
    logic               eret = 1'b0;
    logic [INT_NUM-1:0] int_req = '0;
    logic [INT_NUM-1:0] int_mask = '0;

    logic               pc_stall, ifid_stall, idex_stall;
    logic               ifid_flush, idex_flush, exmem_flush;
    logic               pc_redirect;
    logic [PC_W-1:0]    pc_target;
    logic [INT_NUM-1:0] int_ack;
    logic [PC_W-1:0]    epc;
    logic               in_handler;
    logic [31:0]        lu_stall_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .PC_W    (PC_W),
        .INT_NUM (INT_NUM),
        .VEC_BASE(VEC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_use      (load_use),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .eret          (eret),
        .int_req       (int_req),
        .int_mask      (int_mask),
        .pc_stall      (pc_stall),
        .ifid_stall    (ifid_stall),
        .idex_stall    (idex_stall),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .exmem_flush   (exmem_flush),
        .pc_redirect   (pc_redirect),
        .pc_target     (pc_target),
        .int_ack       (int_ack),
        .epc           (epc),
        .in_handler    (in_handler),
        .lu_stall_cnt  (lu_stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Controller described as: "inside a handler" flag, "one bubble pending"
    // flag, pending-line array, previous request sample, EPC and counter.
    bit               m_hand, m_stall;
    bit [INT_NUM-1:0] m_pend, m_prev;
    logic [31:0]      m_epc, m_cnt;
    bit               e_lu, e_take, e_er, e_br;
    int               e_win;

    task automatic model_reset();
        m_hand = 0; m_stall = 0; m_pend = '0; m_prev = '0;
        m_epc = '0; m_cnt = '0;
    endtask

    task automatic model_eval();
        e_win = -1;
        for (int i = INT_NUM - 1; i >= 0; i--)
            if (m_pend[i] && int_mask[i]) e_win = i;
        e_lu   = !m_stall && load_use && ex_valid;
        e_take = !e_lu && !m_hand && ex_valid && (e_win >= 0);
        e_er   = !e_lu && !e_take && m_hand && eret && ex_valid;
        e_br   = !e_lu && !e_take && !e_er && branch_taken && ex_valid;
    endtask

    task automatic model_update();
        for (int i = 0; i < INT_NUM; i++) begin
            if (e_take && i == e_win) m_pend[i] = 0;
            if (int_req[i] && !m_prev[i]) m_pend[i] = 1;
        end
        m_prev = int_req;
        if (e_take) begin m_epc = ex_pc; m_hand = 1; end
        if (e_er) m_hand = 0;
        m_stall = e_lu;
        if (e_lu && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    endtask

    task automatic compare_model();
        logic [31:0] tgt;
        logic [31:0] ack;
        model_eval();
        tgt = 0; ack = 0;
        if (e_take) begin tgt = VEC + 32'(4 * e_win); ack = 32'(1) << e_win; end
        else if (e_er) tgt = m_epc;
        else if (e_br) tgt = branch_target;
        check("m_pc_stall",    32'(pc_stall),    32'(e_lu));
        check("m_ifid_stall",  32'(ifid_stall),  32'(e_lu));
        check("m_idex_stall",  32'(idex_stall),  32'(e_lu));
        check("m_ifid_flush",  32'(ifid_flush),  32'(e_take | e_er | e_br));
        check("m_idex_flush",  32'(idex_flush),  32'(e_take | e_er | e_br));
        check("m_exmem_flush", 32'(exmem_flush), 32'(e_lu | e_take));
        check("m_redirect",    32'(pc_redirect), 32'(e_take | e_er | e_br));
        check("m_pc_target",   pc_target,        tgt);
        check("m_int_ack",     32'(int_ack),     ack);
        check("m_epc",         epc,              m_epc);
        check("m_in_handler",  32'(in_handler),  32'(m_hand));
        check("m_lu_cnt",      lu_stall_cnt,     m_cnt);
    endtask

    // Inputs are driven just after a falling edge; outputs sampled 1ns later.
    task automatic drive(input bit lu, input bit ev, input logic [31:0] pc,
                         input bit bt, input logic [31:0] tgt, input bit er,
                         input logic [INT_NUM-1:0] req,
                         input logic [INT_NUM-1:0] mask);
        load_use = lu; ex_valid = ev; ex_pc = pc; branch_taken = bt;
        branch_target = tgt; eret = er; int_req = req; int_mask = mask;
        #1;
    endtask

    task automatic tick();
        compare_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load_use = 0; ex_valid = 0; ex_pc = '0; branch_taken = 0;
        branch_target = '0; eret = 0; int_req = '0; int_mask = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          lu, ev, bt, er;
        logic [31:0] tgt;
        bit          x_stall, x_flush2, x_exmem, x_redir;
        logic [31:0] x_target;
        logic [31:0] x_cnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0,0,0,0, 32'h0,        0,0,0,0, 32'h0,        0};
        vecs[1] = '{1,1,0,0, 32'h0,        1,0,1,0, 32'h0,        1};
        vecs[2] = '{1,0,0,0, 32'h0,        0,0,0,0, 32'h0,        0};
        vecs[3] = '{0,1,1,0, 32'h0040_0100, 0,1,0,1, 32'h0040_0100, 0};
        vecs[4] = '{0,0,1,0, 32'h0040_0100, 0,0,0,0, 32'h0,        0};
        vecs[5] = '{0,1,0,1, 32'h0,        0,0,0,0, 32'h0,        0};
        vecs[6] = '{1,1,1,0, 32'h0040_0200, 1,0,1,0, 32'h0,        1};
        vecs[7] = '{0,1,1,1, 32'h0040_0300, 0,1,0,1, 32'h0040_0300, 0};

        // Reset values, with busy inputs held during reset.
        load_use = 1; ex_valid = 1; branch_taken = 1; eret = 1;
        branch_target = 32'h1234_5678;
        #2;
        check("rst_pc_stall",   32'(pc_stall),    0);
        check("rst_exmem",      32'(exmem_flush), 0);
        check("rst_redirect",   32'(pc_redirect), 0);
        check("rst_target",     pc_target,        0);
        check("rst_epc",        epc,              0);
        check("rst_in_handler", 32'(in_handler),  0);
        check("rst_cnt",        lu_stall_cnt,     0);
        do_reset();

        // Table: each vector applied from a freshly reset controller.
        foreach (vecs[k]) begin
            do_reset();
            drive(vecs[k].lu, vecs[k].ev, 32'h0040_0000, vecs[k].bt,
                  vecs[k].tgt, vecs[k].er, '0, 3'b111);
            check($sformatf("v%0d_stall", k),  32'(pc_stall & ifid_stall & idex_stall), 32'(vecs[k].x_stall));
            check($sformatf("v%0d_flush", k),  32'(ifid_flush & idex_flush),           32'(vecs[k].x_flush2));
            check($sformatf("v%0d_exmem", k),  32'(exmem_flush), 32'(vecs[k].x_exmem));
            check($sformatf("v%0d_redir", k),  32'(pc_redirect), 32'(vecs[k].x_redir));
            check($sformatf("v%0d_target", k), pc_target,        vecs[k].x_target);
            tick();
            check($sformatf("v%0d_cnt", k),    lu_stall_cnt,     vecs[k].x_cnt);
        end

        // Load-use in cycle 5 held through cycle 6: one bubble.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(0, 1, 32'h0040_0000 + 32'(4 * c), 0, 0, 0, '0, '0);
            tick();
        end
        drive(1, 1, 32'h0040_0014, 0, 0, 0, '0, '0);
        check("lu5_stall", 32'(pc_stall & ifid_stall & idex_stall & exmem_flush), 1);
        tick();
        drive(1, 1, 32'h0040_0014, 0, 0, 0, '0, '0);
        check("lu6_stall", 32'(pc_stall | ifid_stall | idex_stall | exmem_flush), 0);
        tick();
        drive(0, 1, 32'h0040_0018, 0, 0, 0, '0, '0);
        tick();
        check("lu_cnt_one", lu_stall_cnt, 1);

        // int_req[2] rises; taken the following cycle.
        do_reset();
        drive(0, 1, 32'h0040_001C, 0, 0, 0, 3'b100, 3'b111);
        check("irq_no_early", 32'(int_ack), 0);
        tick();
        drive(0, 1, 32'h0040_0020, 0, 0, 0, 3'b100, 3'b111);
        check("irq_ack",    32'(int_ack),  32'b100);
        check("irq_target", pc_target,     32'h0000_0088);
        check("irq_flush",  32'(ifid_flush & idex_flush & exmem_flush & pc_redirect), 1);
        tick();
        check("irq_epc",    epc,            32'h0040_0020);
        check("irq_inh",    32'(in_handler), 1);

        // Lines 1 and 2 together: 1 first, 2 after ERET.
        do_reset();
        drive(0, 1, 32'h0040_0030, 0, 0, 0, 3'b110, 3'b111);
        tick();
        drive(0, 1, 32'h0040_0040, 0, 0, 0, 3'b110, 3'b111);
        check("two_ack1",   32'(int_ack), 32'b010);
        check("two_tgt1",   pc_target,    32'h0000_0084);
        tick();
        drive(0, 1, 32'h0000_0084, 0, 0, 1, 3'b110, 3'b111);
        check("eret_redir", 32'(pc_redirect), 1);
        check("eret_tgt",   pc_target,        32'h0040_0040);
        check("eret_exmem", 32'(exmem_flush), 0);
        tick();
        check("eret_inh",   32'(in_handler), 0);
        drive(0, 1, 32'h0040_0040, 0, 0, 0, 3'b110, 3'b111);
        check("two_ack2",   32'(int_ack), 32'b100);
        check("two_tgt2",   pc_target,    32'h0000_0088);
        tick();

        // Load-use + branch + pending interrupt together.
        do_reset();
        drive(0, 0, 32'h0, 0, 0, 0, 3'b001, 3'b111);
        tick();
        drive(1, 1, 32'h0040_0050, 1, 32'h0040_0500, 0, 3'b001, 3'b111);
        check("mix_stall",  32'(pc_stall),    1);
        check("mix_redir",  32'(pc_redirect), 0);
        check("mix_ack",    32'(int_ack),     0);
        tick();
        drive(1, 1, 32'h0040_0050, 1, 32'h0040_0500, 0, 3'b001, 3'b111);
        check("mix2_ack",   32'(int_ack),  32'b001);
        check("mix2_tgt",   pc_target,     VEC);
        check("mix2_stall", 32'(pc_stall), 0);
        tick();
        check("mix2_epc",   epc, 32'h0040_0050);

        // Asynchronous reset while in the handler with line 1 pending.
        do_reset();
        drive(0, 1, 32'h0040_0060, 0, 0, 0, 3'b011, 3'b111);
        tick();
        drive(0, 1, 32'h0040_0064, 0, 0, 0, 3'b011, 3'b111);
        tick();
        drive(0, 1, 32'h0000_0080, 1, 32'h0040_0700, 0, 3'b011, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        check("ar_inh",    32'(in_handler),  0);
        check("ar_pend",   32'(dut.pend),    0);
        check("ar_epc",    epc,              0);
        check("ar_redir",  32'(pc_redirect), 0);
        check("ar_target", pc_target,        0);
        check("ar_flush",  32'(ifid_flush | idex_flush | exmem_flush), 0);
        do_reset();

        // Randomized run against the model.
        do_reset();
        begin
            logic [INT_NUM-1:0] req = '0;
            logic [INT_NUM-1:0] mask = 3'b111;
            for (int c = 0; c < 3000; c++) begin
                for (int i = 0; i < INT_NUM; i++)
                    if ($urandom_range(15) == 0) req[i] = ~req[i];
                if ($urandom_range(31) == 0) mask = INT_NUM'($urandom);
                drive($urandom_range(3) == 0, $urandom_range(7) != 0,
                      $urandom & 32'hFFFF_FFFC, $urandom_range(4) == 0,
                      $urandom & 32'hFFFF_FFFC, $urandom_range(3) == 0,
                      req, mask);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
